frame_scheduler: RTL and testbench

Per-frame sequencer and VGA plot-port arbiter for the game. On each frame tick it runs a fixed erase → update → draw → collision-check schedule over the bird and wall drawers. It grants the single VGA plot port to exactly one drawer at a time and latches game-over on collision. It sits between the bird/wall controllers and the VGA adapter.

---
 rtl/frame_scheduler_pkg.sv | 33 +++
 rtl/frame_scheduler_plot_mux.sv | 48 ++++
 rtl/frame_scheduler.sv | 150 +++++++++++++++
 tb/tb_frame_scheduler.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_scheduler_pkg.sv
// Shared types and constants for the frame scheduler.
//   state_t    : per-frame schedule states
//   plot_sel_t : owner of the VGA plot port
//   is_drawer / owner_of : helpers mapping a state to port ownership
package frame_scheduler_pkg;

    localparam int COLOR_W  = 3;
    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    typedef enum logic [3:0] {
        IDLE, WAIT_FRAME, ERASE_WALL, ERASE_BIRD, UPDATE,
        DRAW_WALL, DRAW_BIRD, CHECK, OVER
    } state_t;

    typedef enum logic [1:0] {
        NONE, WALL, BIRD
    } plot_sel_t;

    function automatic logic is_drawer(state_t s);
        return (s == ERASE_WALL) || (s == ERASE_BIRD) ||
               (s == DRAW_WALL)  || (s == DRAW_BIRD);
    endfunction

    function automatic plot_sel_t owner_of(state_t s);
        case (s)
            ERASE_WALL, DRAW_WALL: return WALL;
            ERASE_BIRD, DRAW_BIRD: return BIRD;
            default:               return NONE;
        endcase
    endfunction

endpackage

// File: rtl/frame_scheduler_plot_mux.sv
// plot_mux: combinational 2:1 VGA plot-port mux.
//   plot_sel          : current owner (NONE/WALL/BIRD)
//   wall_* / bird_*   : drawer plot requests
//   vga_*             : arbitrated port; all zero when nobody owns it
module plot_mux
    import frame_scheduler_pkg::*;
#(
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  plot_sel_t          plot_sel,
    input  logic [XW-1:0]      wall_x,
    input  logic [YW-1:0]      wall_y,
    input  logic [COLOR_W-1:0] wall_col,
    input  logic               wall_plot,
    input  logic [XW-1:0]      bird_x,
    input  logic [YW-1:0]      bird_y,
    input  logic [COLOR_W-1:0] bird_col,
    input  logic               bird_plot,
    output logic [XW-1:0]      vga_x,
    output logic [YW-1:0]      vga_y,
    output logic [COLOR_W-1:0] vga_col,
    output logic               vga_plot
);

    always_comb begin
        vga_x    = '0;
        vga_y    = '0;
        vga_col  = '0;
        vga_plot = 1'b0;
        case (plot_sel)
            WALL: begin
                vga_x    = wall_x;
                vga_y    = wall_y;
                vga_col  = wall_col;
                vga_plot = wall_plot;
            end
            BIRD: begin
                vga_x    = bird_x;
                vga_y    = bird_y;
                vga_col  = bird_col;
                vga_plot = bird_plot;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: per-frame erase/update/draw/check sequencer and VGA
// plot-port arbiter for the bird and wall drawers.
//   clk, resetn (async, active-high)
//   go, frame_tick, collision          : control inputs
//   {bird,wall}_{done,x,y,col,plot}    : drawer handshake and plot requests
//   {bird,wall}_start, erase, update_en: schedule strobes
//   vga_{x,y,col,plot}                 : arbitrated plot port
//   game_over, overrun_cnt, timeout_err: status
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd20000,
    parameter int          XW      = $clog2(SCREEN_W),
    parameter int          YW      = $clog2(SCREEN_H)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               go,
    input  logic               frame_tick,
    input  logic               collision,
    input  logic               bird_done,
    input  logic               wall_done,
    input  logic [XW-1:0]      bird_x,
    input  logic [YW-1:0]      bird_y,
    input  logic [COLOR_W-1:0] bird_col,
    input  logic               bird_plot,
    input  logic [XW-1:0]      wall_x,
    input  logic [YW-1:0]      wall_y,
    input  logic [COLOR_W-1:0] wall_col,
    input  logic               wall_plot,
    output logic               bird_start,
    output logic               wall_start,
    output logic               erase,
    output logic               update_en,
    output logic [XW-1:0]      vga_x,
    output logic [YW-1:0]      vga_y,
    output logic [COLOR_W-1:0] vga_col,
    output logic               vga_plot,
    output logic               game_over,
    output logic [7:0]         overrun_cnt,
    output logic               timeout_err
);

    state_t    state, state_nx;
    plot_sel_t plot_sel;
    logic      pending;
    logic [15:0] wd;
    logic      granted_done, timeout_hit, advance, entering, busy;

    // Only the current owner's done counts; the other drawer's pulse is dropped.
    always_comb begin
        granted_done = 1'b0;
        case (owner_of(state))
            WALL:    granted_done = wall_done;
            BIRD:    granted_done = bird_done;
            default: granted_done = 1'b0;
        endcase
    end

    assign timeout_hit = is_drawer(state) && (wd == TIMEOUT);
    assign advance     = granted_done || timeout_hit;
    assign entering    = is_drawer(state_nx) && (state_nx != state);
    // Ticks only matter while a game is actually running.
    assign busy        = (state != IDLE) && (state != WAIT_FRAME) && (state != OVER);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (go) state_nx = WAIT_FRAME;
            WAIT_FRAME: if (frame_tick || pending) state_nx = ERASE_WALL;
            ERASE_WALL: if (advance) state_nx = ERASE_BIRD;
            ERASE_BIRD: if (advance) state_nx = UPDATE;
            UPDATE:     state_nx = DRAW_WALL;
            DRAW_WALL:  if (advance) state_nx = DRAW_BIRD;
            DRAW_BIRD:  if (advance) state_nx = CHECK;
            CHECK:      state_nx = collision ? OVER : WAIT_FRAME;
            OVER:       if (go) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Strobes and owner are registered from the next state so they line up
    // with the first cycle of the state they belong to.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            plot_sel   <= NONE;
            wall_start <= 1'b0;
            bird_start <= 1'b0;
            erase      <= 1'b0;
            update_en  <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            plot_sel   <= owner_of(state_nx);
            wall_start <= entering && (owner_of(state_nx) == WALL);
            bird_start <= entering && (owner_of(state_nx) == BIRD);
            erase      <= (state_nx == ERASE_WALL) || (state_nx == ERASE_BIRD);
            update_en  <= (state_nx == UPDATE);
            game_over  <= (state_nx == OVER);
        end
    end

    // One-deep pending tick plus saturating overrun count.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            pending     <= 1'b0;
            overrun_cnt <= 8'd0;
        end else if (!busy) begin
            pending <= 1'b0;
        end else if (frame_tick) begin
            if (!pending)                  pending     <= 1'b1;
            else if (overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

    // Watchdog reads 1 in the first cycle of a drawer state, so hitting
    // TIMEOUT leaves the state exactly TIMEOUT cycles after entry.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            wd          <= 16'd0;
            timeout_err <= 1'b0;
        end else begin
            if (entering)                wd <= 16'd1;
            else if (is_drawer(state_nx)) wd <= wd + 16'd1;
            else                         wd <= 16'd0;
            if (timeout_hit && !granted_done) timeout_err <= 1'b1;
        end
    end

    plot_mux #(.XW(XW), .YW(YW)) u_plot_mux (
        .plot_sel  (plot_sel),
        .wall_x    (wall_x),
        .wall_y    (wall_y),
        .wall_col  (wall_col),
        .wall_plot (wall_plot),
        .bird_x    (bird_x),
        .bird_y    (bird_y),
        .bird_col  (bird_col),
        .bird_plot (bird_plot),
        .vga_x     (vga_x),
        .vga_y     (vga_y),
        .vga_col   (vga_col),
        .vga_plot  (vga_plot)
    );

endmodule

// File: tb/tb_frame_scheduler.sv
module tb_frame_scheduler;

    localparam logic [15:0] TO = 16'd50;

    logic clk = 1'b0;
    logic resetn, go, frame_tick, collision, bird_done, wall_done;
    logic [7:0] bird_x, wall_x;
    logic [6:0] bird_y, wall_y;
    logic [2:0] bird_col, wall_col;
    logic bird_plot, wall_plot;
    logic bird_start, wall_start, erase, update_en, vga_plot, game_over, timeout_err;
    logic [7:0] vga_x, overrun_cnt;
    logic [6:0] vga_y;
    logic [2:0] vga_col;

    frame_scheduler #(.TIMEOUT(TO), .XW(8), .YW(7)) dut (
        .clk(clk), .resetn(resetn), .go(go), .frame_tick(frame_tick),
        .collision(collision), .bird_done(bird_done), .wall_done(wall_done),
        .bird_x(bird_x), .bird_y(bird_y), .bird_col(bird_col), .bird_plot(bird_plot),
        .wall_x(wall_x), .wall_y(wall_y), .wall_col(wall_col), .wall_plot(wall_plot),
        .bird_start(bird_start), .wall_start(wall_start), .erase(erase),
        .update_en(update_en), .vga_x(vga_x), .vga_y(vga_y), .vga_col(vga_col),
        .vga_plot(vga_plot), .game_over(game_over), .overrun_cnt(overrun_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0, failures = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of schedule strobes: kind 0=wall_start 1=bird_start 2=update_en
    typedef struct packed { logic [1:0] kind; logic erase; } ev_t;
    ev_t exp_q[$];

    function automatic ev_t mk(logic [1:0] k, logic e);
        ev_t v;
        v.kind = k;
        v.erase = e;
        return v;
    endfunction

    // One frame = erase wall, erase bird, update, draw wall, draw bird.
    task automatic push_frame();
        exp_q.push_back(mk(2'd0, 1'b1));
        exp_q.push_back(mk(2'd1, 1'b1));
        exp_q.push_back(mk(2'd2, 1'b0));
        exp_q.push_back(mk(2'd0, 1'b0));
        exp_q.push_back(mk(2'd1, 1'b0));
    endtask

    // Drawer behaviour: done arrives d cycles after the start pulse; the port
    // is owned from start through done, or through TO-1 if the drawer stalls.
    int  d_we = 5, d_be = 5, d_wd = 5, d_bd = 5;
    bit  w_act, b_act, w_draw, b_draw, chk_next, coll_req;
    int  w_cnt, b_cnt, w_d, b_d;
    int  strobes = 0, gap = 0, last_draw_end = 0, bstart_cyc = 0, upd_cyc = 0;

    always @(negedge clk) begin
        if (resetn) begin
            w_act = 0; b_act = 0; chk_next = 0;
            wall_done = 0; bird_done = 0;
        end else begin
            if (wall_start) begin
                w_act = 1; w_cnt = 0; w_draw = !erase;
                w_d = erase ? d_we : d_wd;
                if (erase) gap = cyc - last_draw_end;
            end
            if (bird_start) begin
                b_act = 1; b_cnt = 0; b_draw = !erase;
                b_d = erase ? d_be : d_bd;
                if (erase) bstart_cyc = cyc;
            end
            if (update_en) upd_cyc = cyc;

            if (wall_start || bird_start || update_en) begin
                strobes++;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_strobe: got w=%0d b=%0d u=%0d expected none (cycle %0d)",
                             wall_start, bird_start, update_en, cyc);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("strobe_kind", wall_start ? 0 : (bird_start ? 1 : 2), {30'd0, e.kind});
                    check("strobe_erase", {31'd0, erase}, {31'd0, e.erase});
                end
            end

            // Port contents for this cycle come from inputs driven last negedge.
            if (w_act) begin
                check("vga_wall", {vga_plot, vga_col, vga_y, vga_x},
                      {wall_plot, wall_col, wall_y, wall_x});
                check("erase_wall", {31'd0, erase}, {31'd0, !w_draw});
            end else if (b_act) begin
                check("vga_bird", {vga_plot, vga_col, vga_y, vga_x},
                      {bird_plot, bird_col, bird_y, bird_x});
                check("erase_bird", {31'd0, erase}, {31'd0, !b_draw});
            end else begin
                check("vga_none", {vga_plot, vga_col, vga_y, vga_x}, 0);
            end

            collision = chk_next ? coll_req : 1'($urandom_range(0, 1));
            chk_next = 0;

            if (w_act) begin
                wall_done = (w_cnt == w_d);
                if (w_cnt == w_d || w_cnt == int'(TO) - 1) w_act = 0;
                w_cnt++;
            end else wall_done = ($urandom_range(0, 3) == 0);

            if (b_act) begin
                bird_done = (b_cnt == b_d);
                if (b_cnt == b_d || b_cnt == int'(TO) - 1) begin
                    b_act = 0;
                    if (b_draw) begin chk_next = 1; last_draw_end = cyc; end
                end
                b_cnt++;
            end else bird_done = ($urandom_range(0, 3) == 0);

            wall_x = 8'($urandom); wall_y = 7'($urandom); wall_col = 3'($urandom);
            wall_plot = 1'($urandom);
            bird_x = 8'($urandom); bird_y = 7'($urandom); bird_col = 3'($urandom);
            bird_plot = 1'($urandom);
            if (b_act && b_draw) begin wall_plot = 1; wall_x = 8'd42; end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick_lat();
        frame_tick = 1;
        @(negedge clk);
        frame_tick = 0;
        check("tick_to_wall_start", {31'd0, wall_start}, 1);
    endtask

    task automatic wait_drain(string name, int limit);
        int t = 0;
        while (exp_q.size() != 0 && t < limit) begin
            @(negedge clk);
            t++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int s0, t;
        resetn = 1; go = 0; frame_tick = 0; coll_req = 0; collision = 0;
        bird_done = 0; wall_done = 0;
        bird_x = 0; bird_y = 0; bird_col = 0; bird_plot = 0;
        wall_x = 0; wall_y = 0; wall_col = 0; wall_plot = 0;
        #3;
        check("rst_strobes", {wall_start, bird_start, update_en, erase}, 0);
        check("rst_vga", {vga_plot, vga_col, vga_y, vga_x}, 0);
        check("rst_status", {game_over, timeout_err, overrun_cnt}, 0);
        step(2);
        resetn = 0;
        step(1); go = 1; step(1); go = 0; step(2);

        // Basic frame, drawers done after 5 cycles
        push_frame(); tick_lat(); wait_drain("frame1_drain", 200); step(15);

        for (int i = 0; i < 6; i++) begin
            d_we = $urandom_range(1, 10); d_be = $urandom_range(1, 10);
            d_wd = $urandom_range(1, 10); d_bd = $urandom_range(1, 10);
            push_frame(); tick_lat(); wait_drain("rand_frame_drain", 300); step(15);
        end
        check("no_timeout_yet", {31'd0, timeout_err}, 0);

        // Done on the same cycle the watchdog fires counts as done
        d_we = 49; d_be = 3; d_wd = 3; d_bd = 3;
        push_frame(); tick_lat(); wait_drain("edge_timeout_drain", 300); step(15);
        check("done_at_timeout_no_err", {31'd0, timeout_err}, 0);

        // Three ticks during a long pass: one pending, two overruns
        d_we = 40;
        push_frame(); push_frame();
        tick_lat(); step(5);
        repeat (3) begin frame_tick = 1; step(1); frame_tick = 0; step(4); end
        wait_drain("overrun_drain", 400); step(15);
        check("overrun_cnt", {24'd0, overrun_cnt}, 2);
        check("pending_frame_gap", gap, 3);

        // Stalled bird drawer: watchdog forces the advance
        d_we = 3; d_be = 1000;
        push_frame(); tick_lat(); wait_drain("timeout_drain", 400); step(15);
        check("timeout_advance", upd_cyc - bstart_cyc, int'(TO));
        check("timeout_err_set", {31'd0, timeout_err}, 1);
        d_be = 5;

        // Collision ends the game
        coll_req = 1;
        push_frame(); tick_lat(); wait_drain("collision_drain", 300); step(15);
        coll_req = 0;
        check("game_over_set", {31'd0, game_over}, 1);
        s0 = strobes;
        repeat (2) begin frame_tick = 1; step(1); frame_tick = 0; step(8); end
        check("over_no_starts", strobes - s0, 0);
        check("game_over_sticky", {31'd0, game_over}, 1);
        go = 1; step(1); go = 0; step(1);
        check("go_clears_game_over", {31'd0, game_over}, 0);
        go = 1; step(1); go = 0; step(2);

        // Reset in the middle of DRAW_WALL
        d_wd = 30;
        push_frame(); tick_lat();
        t = 0;
        while (!(wall_start && !erase) && t < 200) begin @(negedge clk); t++; end
        check("reached_draw_wall", t < 200, 1);
        #2 resetn = 1;
        #1;
        check("async_rst_strobes", {wall_start, bird_start, update_en, erase}, 0);
        check("async_rst_vga", {vga_plot, vga_col, vga_y, vga_x}, 0);
        check("async_rst_status", {game_over, timeout_err, overrun_cnt}, 0);
        exp_q.delete();
        step(2);
        resetn = 0;
        step(5);
        check("idle_after_reset", {wall_start, bird_start, update_en, vga_plot}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
